aes_out_serializer: RTL
=======================

# aes_out_serializer

Downstream stage of the AES-128 core. It accepts complete 128-bit cipher blocks over a valid/ready handshake and emits them as a stream of narrower words on a second valid/ready handshake. It carries one block in the shifter and one in a pending register, so a new block can be loaded with no bubble between blocks. It sits between the AES result register and the word-wide output/bus interface.

## Interface
- WORD_W, 32: output word width; legal values 8, 16, 32, 64. Any other value must fail elaboration.
- MSW_FIRST, 1: 1 = most-significant word first; 0 = least-significant word first.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  in_data holds a valid block.
- in_ready  out  1  block accepted at a rising edge where in_valid && in_ready.
- in_data  in  128  cipher block.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  word consumed at a rising edge where out_valid && out_ready.
- out_data  out  WORD_W  current word.
- out_last  out  1  out_data is the final word of its block.
- block_cnt  out  16  number of blocks fully emitted; wraps at 16'hFFFF to 0.

## Operation
- Derived constant: N = 128/WORD_W words per block.
- State:
  - shift register SR (128 bits);
  - word index idx, range 0..N-1;
  - flag sr_full;
  - pending register PR (128 bits);
  - flag pr_full.
- in_ready = !pr_full. It depends only on registered state and never combinationally on out_ready.
- out_valid = sr_full.
- out_data:
  - MSW_FIRST=1: SR[127 -: WORD_W].
  - MSW_FIRST=0: SR[WORD_W-1:0].
- out_last = sr_full && (idx == N-1).
- On each word handshake:
  - SR shifts by WORD_W toward the emitting end.
  - idx increments.
- On the last-word handshake:
  - idx returns to 0.
  - block_cnt increments.
  - If pr_full: SR <= PR, pr_full clears, sr_full stays 1.
  - Otherwise sr_full clears.
- On input accept:
  - If SR is free after this edge (sr_full=0, or the last-word handshake occurs this same edge with pr_full=0): SR <= in_data, sr_full sets.
  - Otherwise: PR <= in_data, pr_full sets.
- Simultaneous accept, last-word handshake and pr_full=1 cannot occur, because in_ready=0 while pr_full=1.
- out_data must not change while out_valid=1 and out_ready=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, block_cnt=0; SR, PR, idx, sr_full and pr_full all cleared.
- A reset asserted mid-block discards the partial block and any pending block; no further words of either are emitted.
- Latency: out_valid rises 1 cycle after input accept when the serializer is empty.
- Throughput with out_ready held high: one word per cycle, so N cycles per block. Back-to-back blocks have no idle cycle between the last word of block k and the first word of block k+1.
- block_cnt updates on the edge of the last-word handshake and is visible the following cycle.
- in_ready deasserts the cycle after PR fills. It reasserts the cycle after the last-word handshake that drains PR into SR.

## Configuration
- AES_SER_PARITY_EN defined:
  - Adds output port out_parity (1 bit) = ^out_data (even parity over the word).
  - out_parity is valid whenever out_valid=1 and is 0 in reset.
- AES_SER_PARITY_EN undefined:
  - Port out_parity is absent.
  - No parity logic is built.
  - All other behaviour is identical.

## Test plan
- Basic order:
  - Stimulus: WORD_W=32, MSW_FIRST=1, out_ready=1; accept 128'h00112233_44556677_8899aabb_ccddeeff.
  - Required: words 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff on cycles 1–4 after accept; out_last only on the 4th word; block_cnt=1 afterwards.
- Reversed order:
  - Stimulus: same block with MSW_FIRST=0, WORD_W=16.
  - Required: 8 words 0xeeff, 0xccdd, … 0x0011; out_last on the 8th word.
- Back-to-back blocks:
  - Stimulus: two blocks offered on consecutive cycles, out_ready=1.
  - Required: 8 contiguous words with no bubble; in_ready low for exactly the cycles while PR is full; block_cnt=2.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles mid-block.
  - Required: out_data and out_last stable throughout; a third offered block is refused (in_ready=0) while SR and PR are both full.
- Reset mid-operation:
  - Stimulus: assert rst after 2 of 4 words have been emitted, with PR full.
  - Required: the next cycle shows out_valid=0, in_ready=1, block_cnt=0; the next block accepted after reset emits starting from its first word.
- Parity and counter wrap:
  - Stimulus: build with AES_SER_PARITY_EN; word 0x00000001; separately, preload by streaming 65536 blocks.
  - Required: out_parity=1 on the word 0x00000001; block_cnt wraps to 0 after 65536 blocks.

Source files
------------

// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Takes complete 128-bit AES cipher blocks on a valid/ready input handshake
// and emits them as WORD_W-bit words on a valid/ready output handshake.
// One block is held in the shift register (SR) being emitted and a second
// one can wait in the pending register (PR). This lets consecutive blocks
// stream out with no idle cycle between them.
//
// Parameters:
//   WORD_W     output word width; one of 8, 16, 32, 64 (others fail elaboration)
//   MSW_FIRST  1 = most-significant word first, 0 = least-significant first
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data carries a block
//   in_ready   a block can be accepted (pending register empty)
//   in_data    128-bit cipher block
//   out_valid  out_data carries a word
//   out_ready  downstream consumes the word this edge
//   out_data   current word
//   out_last   current word is the final word of its block
//   out_parity even parity of out_data (only with AES_SER_PARITY_EN)
//   block_cnt  number of blocks fully emitted, wraps at 16'hFFFF
//
// Optional feature macro: AES_SER_PARITY_EN adds the out_parity port.
// ---------------------------------------------------------------------------
module aes_out_serializer #(
    parameter int WORD_W    = 32,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
`ifdef AES_SER_PARITY_EN
    output logic              out_parity,
`endif
    output logic [15:0]       block_cnt
);

    localparam int N     = 128 / WORD_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Reject unsupported word widths at elaboration time.
    generate
        if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
            $error("aes_out_serializer: WORD_W must be 8, 16, 32 or 64");
        end
    endgenerate

`ifdef AES_SER_PARITY_EN
    function automatic logic parity_even(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction
`endif

    logic [127:0]      sr_r, sr_nxt_s, sr_shifted_s;
    logic [127:0]      pr_r, pr_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic              sr_full_r, sr_full_nxt_s;
    logic              pr_full_r, pr_full_nxt_s;
    logic [15:0]       cnt_r, cnt_nxt_s;

    logic              word_hs_s;
    logic              last_hs_s;
    logic              accept_s;
    logic              sr_free_s;

    assign word_hs_s = sr_full_r && out_ready;
    assign last_hs_s = word_hs_s && (idx_r == LAST_IDX);
    assign accept_s  = in_valid && !pr_full_r;
    // SR can take the incoming block if it is empty, or if its last word
    // leaves this edge and nothing is waiting in PR to refill it.
    assign sr_free_s = !sr_full_r || (last_hs_s && !pr_full_r);

    // Shift toward the emitting end; vacated bits fill with zero so an
    // exhausted SR reads back as zero.
    generate
        if (MSW_FIRST) begin : g_msw
            assign sr_shifted_s = sr_r << WORD_W;
            assign out_data     = sr_r[127 -: WORD_W];
        end else begin : g_lsw
            assign sr_shifted_s = sr_r >> WORD_W;
            assign out_data     = sr_r[WORD_W-1:0];
        end
    endgenerate

    assign in_ready  = !pr_full_r;
    assign out_valid = sr_full_r;
    assign out_last  = sr_full_r && (idx_r == LAST_IDX);
    assign block_cnt = cnt_r;

`ifdef AES_SER_PARITY_EN
    assign out_parity = parity_even(out_data);
`endif

    // Next-state computation for the shifter, pending register and counters.
    always_comb begin
        sr_nxt_s      = sr_r;
        pr_nxt_s      = pr_r;
        idx_nxt_s     = idx_r;
        sr_full_nxt_s = sr_full_r;
        pr_full_nxt_s = pr_full_r;
        cnt_nxt_s     = cnt_r;

        if (word_hs_s) begin
            sr_nxt_s = sr_shifted_s;
            if (last_hs_s) begin
                idx_nxt_s = {IDX_W{1'b0}};
                cnt_nxt_s = cnt_r + 16'd1;
                if (pr_full_r) begin
                    sr_nxt_s      = pr_r;
                    pr_full_nxt_s = 1'b0;
                end else begin
                    sr_full_nxt_s = 1'b0;
                end
            end else begin
                idx_nxt_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            sr_nxt_s = sr_r;
        end

        // Accept never coincides with a PR drain because in_ready is low
        // whenever PR is full, so these assignments cannot clash.
        if (accept_s) begin
            if (sr_free_s) begin
                sr_nxt_s      = in_data;
                sr_full_nxt_s = 1'b1;
            end else begin
                pr_nxt_s      = in_data;
                pr_full_nxt_s = 1'b1;
            end
        end else begin
            pr_nxt_s = pr_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r      <= {128{1'b0}};
            pr_r      <= {128{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            sr_full_r <= 1'b0;
            pr_full_r <= 1'b0;
            cnt_r     <= 16'd0;
        end else begin
            sr_r      <= sr_nxt_s;
            pr_r      <= pr_nxt_s;
            idx_r     <= idx_nxt_s;
            sr_full_r <= sr_full_nxt_s;
            pr_full_r <= pr_full_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

endmodule
